// File: rtl/id_stage_pipe.sv
// id_stage_pipe: LEGv8 decode stage with ID/EX pipeline register, register
// file and load-use hazard detection.
// Optional feature: define ID_WB_BYPASS_EN to forward write-back data
// straight to the read ports in the same cycle (write-through register file).
module id_stage_pipe #(
    parameter int DATA_W = 64,
    parameter int NREG   = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_reg2loc,
    output logic              ex_alusrc,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic [1:0]        ex_aluop,
    output logic [10:0]       ex_opcode,
    output logic [DATA_W-1:0] ex_rdata_a,
    output logic [DATA_W-1:0] ex_rdata_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [AW-1:0]     ex_rd
);

    localparam logic [AW-1:0] XZR     = AW'(NREG - 1);
    localparam logic [10:0]   OP_ADD  = 11'b10001011000;
    localparam logic [10:0]   OP_SUB  = 11'b11001011000;
    localparam logic [10:0]   OP_AND  = 11'b10001010000;
    localparam logic [10:0]   OP_ORR  = 11'b10101010000;
    localparam logic [10:0]   OP_LDUR = 11'b11111000010;
    localparam logic [10:0]   OP_STUR = 11'b11111000000;
    localparam logic [10:0]   OP_CBZ  = 11'b10110100???;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    logic [DATA_W-1:0] regs_q [NREG];

    logic [10:0]       opcode;
    ctrl_t             ctrl;
    logic              legal;
    logic              b_used;
    logic [DATA_W-1:0] imm;
    logic [AW-1:0]     idx_a;
    logic [AW-1:0]     idx_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              haz;

    logic              ex_valid_d,  ex_valid_q;
    ctrl_t             ex_ctrl_d,   ex_ctrl_q;
    logic [10:0]       ex_opcode_q;
    logic [DATA_W-1:0] ex_rdata_a_q, ex_rdata_b_q, ex_imm_q;
    logic [AW-1:0]     ex_rd_q;

    assign opcode = if_instr[31:21];

    // Decode control bits, legality, B-port usage and the sign-extended immediate.
    always_comb begin
        ctrl   = '0;
        legal  = 1'b0;
        b_used = 1'b0;
        imm    = '0;
        casez (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = 2'b10;
                legal         = 1'b1;
                b_used        = 1'b1;
            end
            OP_LDUR: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
                legal         = 1'b1;
                imm           = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
            end
            OP_STUR: begin
                ctrl.reg2loc  = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                legal         = 1'b1;
                b_used        = 1'b1;
                imm           = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
            end
            OP_CBZ: begin
                ctrl.reg2loc  = 1'b1;
                ctrl.branch   = 1'b1;
                ctrl.aluop    = 2'b01;
                legal         = 1'b1;
                b_used        = 1'b1;
                imm           = {{(DATA_W-19){if_instr[23]}}, if_instr[23:5]};
            end
            default: ;
        endcase
    end

    assign idx_a = AW'(if_instr[9:5]);
    assign idx_b = ctrl.reg2loc ? AW'(if_instr[4:0]) : AW'(if_instr[20:16]);

    // Combinational register reads; XZR (and anything above it) reads as zero.
    always_comb begin
        rdata_a = (idx_a < XZR) ? regs_q[idx_a] : '0;
        rdata_b = (idx_b < XZR) ? regs_q[idx_b] : '0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_addr == idx_a && idx_a < XZR) rdata_a = wb_data;
        if (wb_we && wb_addr == idx_b && idx_b < XZR) rdata_b = wb_data;
`endif
    end

    // Load-use hazard: the load in EX targets a register this instruction reads.
    assign haz = if_valid & ex_valid_q & ex_ctrl_q.memread & (ex_rd_q != XZR) &
                 ((ex_rd_q == idx_a) | (b_used & (ex_rd_q == idx_b)));
    // A flush squashes the consumer anyway, so there is nothing to hold.
    assign stall = haz & ~flush;

    // Choose between a bubble and the decoded instruction for ID/EX.
    always_comb begin
        ex_valid_d = ~(flush | haz) & if_valid & legal;
        ex_ctrl_d  = ex_valid_d ? ctrl : '0;
    end

    // Register file write port; XZR writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the register file is reset explicitly because reads after reset must return 0;
        // this keeps it out of RAM macros, which is acceptable at 32 entries.
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wb_we && wb_addr < XZR) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // ID/EX pipeline register; data fields load every cycle, bubbles only clear control.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_opcode_q  <= '0;
            ex_rdata_a_q <= '0;
            ex_rdata_b_q <= '0;
            ex_imm_q     <= '0;
            ex_rd_q      <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_opcode_q  <= opcode;
            ex_rdata_a_q <= rdata_a;
            ex_rdata_b_q <= rdata_b;
            ex_imm_q     <= imm;
            ex_rd_q      <= AW'(if_instr[4:0]);
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_reg2loc  = ex_ctrl_q.reg2loc;
    assign ex_alusrc   = ex_ctrl_q.alusrc;
    assign ex_memtoreg = ex_ctrl_q.memtoreg;
    assign ex_regwrite = ex_ctrl_q.regwrite;
    assign ex_memread  = ex_ctrl_q.memread;
    assign ex_memwrite = ex_ctrl_q.memwrite;
    assign ex_branch   = ex_ctrl_q.branch;
    assign ex_aluop    = ex_ctrl_q.aluop;
    assign ex_opcode   = ex_opcode_q;
    assign ex_rdata_a  = ex_rdata_a_q;
    assign ex_rdata_b  = ex_rdata_b_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd       = ex_rd_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: scoreboard bench for id_stage_pipe. Expected ID/EX contents
// are computed from a reference decode table and register model when the
// instruction is presented, queued, and compared one cycle later.
module tb_id_stage_pipe;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        stall, ex_valid;
    logic        ex_reg2loc, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [1:0]  ex_aluop;
    logic [10:0] ex_opcode;
    logic [63:0] ex_rdata_a, ex_rdata_b, ex_imm;
    logic [4:0]  ex_rd;
    logic [8:0]  ex_ctrl;

    assign ex_ctrl = {ex_reg2loc, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                      ex_memwrite, ex_branch, ex_aluop};

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(64), .NREG(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
        .ex_valid(ex_valid), .ex_reg2loc(ex_reg2loc), .ex_alusrc(ex_alusrc),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_aluop(ex_aluop),
        .ex_opcode(ex_opcode), .ex_rdata_a(ex_rdata_a), .ex_rdata_b(ex_rdata_b),
        .ex_imm(ex_imm), .ex_rd(ex_rd)
    );

    typedef struct packed {
        logic        legal;
        logic [8:0]  ctrl;
        logic        b_used;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [63:0] imm;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [8:0]  ctrl;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [10:0] opcode;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] m_regs [32];
    logic        m_ex_valid;
    logic        m_ex_memread;
    logic [4:0]  m_ex_rd;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] r_ins(logic [10:0] op, int rd, int rn, int rm);
        return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
    endfunction

    function automatic logic [31:0] d_ins(logic [10:0] op, int rt, int rn, int imm9);
        return {op, 9'(imm9), 2'b00, 5'(rn), 5'(rt)};
    endfunction

    function automatic logic [31:0] cbz_ins(int rt, int imm19);
        return {8'b10110100, 19'(imm19), 5'(rt)};
    endfunction

    // Reference decode straight from the instruction table.
    function automatic dec_t decode_model(logic [31:0] ins);
        dec_t d;
        logic [10:0] op;
        op = ins[31:21];
        d = '0;
        d.a = ins[9:5];
        d.b = ins[20:16];
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
            d.legal = 1'b1; d.ctrl = 9'b000100010; d.b_used = 1'b1;
        end else if (op == OP_LDUR) begin
            d.legal = 1'b1; d.ctrl = 9'b011110000;
            d.imm = {{55{ins[20]}}, ins[20:12]};
        end else if (op == OP_STUR) begin
            d.legal = 1'b1; d.ctrl = 9'b110001000; d.b_used = 1'b1; d.b = ins[4:0];
            d.imm = {{55{ins[20]}}, ins[20:12]};
        end else if (op[10:3] == 8'b10110100) begin
            d.legal = 1'b1; d.ctrl = 9'b100000101; d.b_used = 1'b1; d.b = ins[4:0];
            d.imm = {{45{ins[23]}}, ins[23:5]};
        end
        return d;
    endfunction

    function automatic logic [63:0] m_read(logic [4:0] idx, logic we, logic [4:0] wa, logic [63:0] wd);
        if (idx == 5'd31) return 64'd0;
`ifdef ID_WB_BYPASS_EN
        if (we && wa == idx) return wd;
`endif
        return m_regs[idx];
    endfunction

    // One cycle, starting and ending on a falling edge: drive, check stall,
    // queue the expected ID/EX contents, clock, then compare.
    task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        output logic stalled);
        dec_t d;
        exp_t e, got_e;
        logic h;
        if_valid = v; if_instr = ins; flush = fl; wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
        d = decode_model(ins);
        h = v && m_ex_valid && m_ex_memread && (m_ex_rd != 5'd31) &&
            (m_ex_rd == d.a || (d.b_used && m_ex_rd == d.b));
        check("stall", 64'(stall), 64'(h && !fl));
        e = '0;
        e.valid  = !(fl || h) && v && d.legal;
        e.ctrl   = e.valid ? d.ctrl : 9'd0;
        e.ra     = m_read(d.a, we, wa, wd);
        e.rb     = m_read(d.b, we, wa, wd);
        e.imm    = d.imm;
        e.rd     = ins[4:0];
        e.opcode = ins[31:21];
        sb.push_back(e);
        m_ex_valid   = e.valid;
        m_ex_memread = e.ctrl[4];
        m_ex_rd      = ins[4:0];
        @(posedge clk);
        if (we && wa != 5'd31) m_regs[wa] = wd;
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            got_e = sb.pop_front();
            check("ex_valid", 64'(ex_valid), 64'(got_e.valid));
            check("ex_ctrl", 64'(ex_ctrl), 64'(got_e.ctrl));
            if (got_e.valid) begin
                check("ex_rdata_a", ex_rdata_a, got_e.ra);
                check("ex_rdata_b", ex_rdata_b, got_e.rb);
                check("ex_imm", ex_imm, got_e.imm);
                check("ex_rd", 64'(ex_rd), 64'(got_e.rd));
                check("ex_opcode", 64'(ex_opcode), 64'(got_e.opcode));
            end
        end
        stalled = h && !fl;
    endtask

    // Present an instruction and hold it while stalled, like IF/ID would.
    task automatic issue(input logic [31:0] ins, output int n_stall);
        logic s;
        n_stall = 0;
        step(1'b1, ins, 1'b0, 1'b0, 5'd0, 64'd0, s);
        while (s && n_stall < 4) begin
            n_stall++;
            step(1'b1, ins, 1'b0, 1'b0, 5'd0, 64'd0, s);
        end
    endtask

    task automatic wb(input int addr, input logic [63:0] data);
        logic s;
        step(1'b0, 32'd0, 1'b0, 1'b1, 5'(addr), data, s);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_ex_valid = 1'b0; m_ex_memread = 1'b0; m_ex_rd = 5'd0;
        sb.delete();
    endtask

    // Asynchronous reset between edges: outputs must clear without a clock.
    task automatic do_reset(input string tag);
        if_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
        rst_n = 1'b0;
        #1;
        check({tag, "_valid"}, 64'(ex_valid), 64'd0);
        check({tag, "_ctrl"}, 64'(ex_ctrl), 64'd0);
        check({tag, "_stall"}, 64'(stall), 64'd0);
        check({tag, "_rdata_a"}, ex_rdata_a, 64'd0);
        check({tag, "_rd"}, 64'(ex_rd), 64'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ns;
        logic s;
        rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; flush = 1'b0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 64'd0;
        clear_model();
        repeat (2) @(negedge clk);
        do_reset("por");

        // Populate, issue one valid instruction, then reset mid-stream.
        wb(0, 64'd5); wb(1, 64'd7); wb(2, 64'd9);
        issue(r_ins(OP_ADD, 3, 1, 2), ns);
        check("add_pre_rst_valid", 64'(ex_valid), 64'd1);
        do_reset("arst");
        issue(r_ins(OP_ADD, 3, 0, 0), ns);
        check("x0_after_rst", ex_rdata_a, 64'd0);

        wb(1, 64'd7); wb(2, 64'd9); wb(4, 64'h11); wb(31, 64'h55);

        // Main decode patterns.
        issue(r_ins(OP_ADD, 3, 1, 2), ns);
        check("add_rdata_a", ex_rdata_a, 64'd7);
        check("add_rdata_b", ex_rdata_b, 64'd9);
        issue(r_ins(OP_SUB, 3, 2, 1), ns);
        issue(r_ins(OP_AND, 8, 1, 2), ns);
        issue(r_ins(OP_ORR, 9, 2, 4), ns);
        issue(d_ins(OP_STUR, 2, 1, 16), ns);
        issue(cbz_ins(3, -4), ns);
        issue(cbz_ins(2, 100), ns);
        issue(r_ins(OP_ADD, 12, 31, 31), ns);
        check("xzr_read", ex_rdata_a, 64'd0);

        // Load-use: one stall, one bubble, then the consumer issues.
        issue(d_ins(OP_LDUR, 5, 1, -8), ns);
        check("ldur_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        issue(r_ins(OP_ADD, 6, 5, 2), ns);
        check("ld_use_stalls", 64'(ns), 64'd1);

        // Hazard through the B port (CBZ reads Rt).
        issue(d_ins(OP_LDUR, 3, 1, 0), ns);
        issue(cbz_ins(3, 8), ns);
        check("cbz_b_stalls", 64'(ns), 64'd1);

        // Load not consumed next: no stall.
        issue(d_ins(OP_LDUR, 13, 1, 24), ns);
        issue(r_ins(OP_ORR, 14, 1, 2), ns);
        check("no_dep_stalls", 64'(ns), 64'd0);

        // Load into XZR never stalls a reader of X31.
        issue(d_ins(OP_LDUR, 31, 1, 8), ns);
        issue(r_ins(OP_ADD, 7, 31, 1), ns);
        check("xzr_ld_stalls", 64'(ns), 64'd0);

        // Flush coincident with a hazard: no stall, bubble, next instruction not duplicated.
        issue(d_ins(OP_LDUR, 8, 1, 0), ns);
        step(1'b1, r_ins(OP_ADD, 9, 8, 1), 1'b1, 1'b0, 5'd0, 64'd0, s);
        check("flush_stall", 64'(s), 64'd0);
        issue(r_ins(OP_ORR, 10, 1, 2), ns);
        check("post_flush_stalls", 64'(ns), 64'd0);

        // Write-back to a register read in the same cycle.
        step(1'b1, r_ins(OP_ADD, 11, 4, 1), 1'b0, 1'b1, 5'd4, 64'hAB, s);
`ifdef ID_WB_BYPASS_EN
        check("wb_same_cycle", ex_rdata_a, 64'hAB);
`else
        check("wb_same_cycle", ex_rdata_a, 64'h11);
`endif
        issue(r_ins(OP_ADD, 11, 4, 1), ns);
        check("wb_next_cycle", ex_rdata_a, 64'hAB);

        // Illegal opcode and invalid slot both produce bubbles.
        issue(32'hFFFF_FFFF, ns);
        step(1'b0, r_ins(OP_ADD, 3, 1, 2), 1'b0, 1'b0, 5'd0, 64'd0, s);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
